// File: rtl/flp_relu_pack.sv
// Packs a stream of 32-bit ReLU results into 64-bit element pairs (low element first)
// and buffers them in a small FIFO. It also keeps a saturating count of accepted zero results.
module flp_relu_pack #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic [1:0]  o_mask,
    output logic        o_last,
    input  logic        i_ready,
    input  logic        i_zclr,
    output logic [15:0] o_zcnt,
    output logic        o_busy
);
    // state | meaning
    // EMPTY | no element held, next element starts a word
    // HALF  | low element held in low_q, waiting for its partner
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t                state_q;
    state_t                state_d;
    logic [31:0]           low_q;
    logic                  load_low;
    logic                  push;
    logic [66:0]           push_word;
    logic [66:0]           mem [DEPTH];
    logic [66:0]           head;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  accept;
    logic                  pop;
    logic [15:0]           zcnt_q;

    // Pointers carry one extra MSB so that full and empty can be told apart.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign o_ready = !fifo_full;
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_word = '0;
        load_low  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (i_last) begin
                        push      = 1'b1;
                        push_word = {1'b1, 2'b01, 32'h0, i_data};
                    end else begin
                        load_low = 1'b1;
                        state_d  = HALF;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    push      = 1'b1;
                    push_word = {i_last, 2'b11, i_data, low_q};
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            low_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (load_low) low_q <= i_data;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_word;
    end

    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? 64'h0 : head[63:0];
    assign o_mask  = fifo_empty ? 2'b00 : head[65:64];
    assign o_last  = fifo_empty ? 1'b0  : head[66];

    // A clear takes priority over a zero accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_zclr) begin
            zcnt_q <= '0;
        end else if (accept && (i_data[30:0] == 31'd0) && (zcnt_q != 16'hFFFF)) begin
            zcnt_q <= zcnt_q + 16'd1;
        end
    end

    assign o_zcnt = zcnt_q;
    assign o_busy = (state_q == HALF) || !fifo_empty;

endmodule

// File: tb/tb_flp_relu_pack.sv
// Directed stimulus for flp_relu_pack, checked against a queue-based reference model
// and against hand-computed values.
module tb_flp_relu_pack;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_last = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [63:0] o_data;
    logic [1:0]  o_mask;
    logic        o_last;
    logic        i_ready = 1'b0;
    logic        i_zclr = 1'b0;
    logic [15:0] o_zcnt;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    flp_relu_pack #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_mask  (o_mask),
        .o_last  (o_last),
        .i_ready (i_ready),
        .i_zclr  (i_zclr),
        .o_zcnt  (o_zcnt),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: each queue entry is {last, mask[1:0], data[63:0]}.
    logic [66:0] mq[$];
    bit          m_pending = 0;
    logic [31:0] m_low = '0;
    int          m_zcnt = 0;
    bit          live = 0;

    always @(posedge clk) begin
        bit acc;
        bit pp;
        if (rst) begin
            mq.delete();
            m_pending = 0;
            m_low     = '0;
            m_zcnt    = 0;
            live      = 1;
        end else if (live) begin
            acc = i_valid && (mq.size() < DEPTH);
            pp  = (mq.size() > 0) && i_ready;
            if (i_zclr) m_zcnt = 0;
            else if (acc && i_data[30:0] == 0 && m_zcnt < 65535) m_zcnt = m_zcnt + 1;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                if (m_pending) begin
                    mq.push_back({i_last, 2'b11, i_data, m_low});
                    m_pending = 0;
                end else if (i_last) begin
                    mq.push_back({1'b1, 2'b01, 32'h0, i_data});
                end else begin
                    m_pending = 1;
                    m_low     = i_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("o_valid", 64'(o_valid), 64'(mq.size() > 0));
            check("o_ready", 64'(o_ready), 64'(mq.size() < DEPTH));
            check("o_busy", 64'(o_busy), 64'(m_pending || mq.size() > 0));
            check("o_zcnt", 64'(o_zcnt), 64'(m_zcnt));
            if (mq.size() > 0) begin
                check("o_data", o_data, mq[0][63:0]);
                check("o_mask", 64'(o_mask), 64'(mq[0][65:64]));
                check("o_last", 64'(o_last), 64'(mq[0][66]));
            end else begin
                check("o_data_idle", o_data, 64'h0);
                check("o_mask_idle", 64'(o_mask), 64'h0);
                check("o_last_idle", 64'(o_last), 64'h0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'(n), 64'(0));
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_ready", 64'(o_ready), 64'h1);
        check("rst_busy", 64'(o_busy), 64'h0);
        rst = 1'b0;
        i_ready = 1'b1;

        // Full pair closing a packet
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        check("pair_valid", 64'(o_valid), 64'h1);
        check("pair_data", o_data, 64'h40000000_3F800000);
        check("pair_mask", 64'(o_mask), 64'h3);
        check("pair_last", 64'(o_last), 64'h1);

        // Single zero element, then negative zero
        send(32'h00000000, 1'b1);
        check("single_data", o_data, 64'h0);
        check("single_mask", 64'(o_mask), 64'h1);
        check("single_last", 64'(o_last), 64'h1);
        check("zcnt_pos0", 64'(o_zcnt), 64'd1);
        send(32'h80000000, 1'b1);
        check("zcnt_neg0", 64'(o_zcnt), 64'd2);
        check("neg0_data", o_data, 64'h00000000_80000000);
        @(negedge clk);

        // Fill the FIFO with downstream stalled, then drain it in order
        i_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send(32'(k), 1'b0);
        check("full_ready", 64'(o_ready), 64'h0);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_data", o_data, {32'(2 * k + 2), 32'(2 * k + 1)});
            check("drain_mask", 64'(o_mask), 64'h3);
            if (k == 0) check("ready_before_pop", 64'(o_ready), 64'h0);
            if (k == 1) check("ready_after_pop", 64'(o_ready), 64'h1);
            @(negedge clk);
        end
        check("drained", 64'(o_valid), 64'h0);

        // Odd-length packet, including NaN and Inf bit patterns
        send(32'h7FC00001, 1'b0);
        send(32'h7F800000, 1'b0);
        check("odd_w0_data", o_data, 64'h7F800000_7FC00001);
        check("odd_w0_last", 64'(o_last), 64'h0);
        send(32'h00000123, 1'b1);
        check("odd_w1_data", o_data, 64'h00000000_00000123);
        check("odd_w1_mask", 64'(o_mask), 64'h1);
        check("odd_w1_last", 64'(o_last), 64'h1);
        @(negedge clk);

        // Reset while HALF with two words buffered
        i_ready = 1'b0;
        send(32'h0, 1'b0);
        for (int k = 0; k < 4; k++) send(32'h11 + 32'(k), 1'b0);
        check("pre_rst_busy", 64'(o_busy), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_valid", 64'(o_valid), 64'h0);
        check("post_rst_busy", 64'(o_busy), 64'h0);
        check("post_rst_zcnt", 64'(o_zcnt), 64'h0);
        i_ready = 1'b1;
        send(32'hAAAA0001, 1'b0);
        send(32'hBBBB0002, 1'b1);
        check("post_rst_data", o_data, 64'hBBBB0002_AAAA0001);
        check("post_rst_mask", 64'(o_mask), 64'h3);
        @(negedge clk);

        // Saturation of the zero counter, then clear beating a same-cycle zero
        i_valid = 1'b1;
        i_data  = 32'h0;
        i_last  = 1'b0;
        repeat (65534) @(negedge clk);
        i_valid = 1'b0;
        check("zcnt_fffe", 64'(o_zcnt), 64'hFFFE);
        for (int k = 0; k < 3; k++) send(32'h80000000, 1'b0);
        check("zcnt_sat", 64'(o_zcnt), 64'hFFFF);
        i_zclr = 1'b1;
        send(32'h0, 1'b1);
        i_zclr = 1'b0;
        check("zcnt_clr", 64'(o_zcnt), 64'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/flp_relu_pack.md
Name: flp_relu_pack

Overview:
- Downstream neighbour of the FP32 ReLU stage (flp_relu, EWIDTH=8, SWIDTH=23).
- Consumes the stream of 32-bit ReLU results and packs element pairs into 64-bit words, low element first.
- Packed words are buffered in a small FIFO feeding the vector writeback path.
- A packet-end flag flushes half-filled words; a saturating counter reports zero results, used for sparsity statistics.

Parameters:
- DEPTH_LOG2, 2, log2 of output FIFO depth in 64-bit entries (depth 4 by default; legal range 1..4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- i_valid  input  1  ReLU result valid.
- i_data  input  32  FP32 ReLU result.
- i_last  input  1  element is last of packet; qualified by i_valid.
- o_ready  output  1  packer can accept an element this cycle.
- o_valid  output  1  packed word available at FIFO head.
- o_data  output  64  packed word; [31:0] = even element, [63:32] = odd element.
- o_mask  output  2  element-valid mask of o_data; 2'b01 = low only, 2'b11 = both.
- o_last  output  1  word carries the last element of a packet.
- i_ready  input  1  downstream accepts the head word.
- i_zclr  input  1  clears the zero counter.
- o_zcnt  output  16  count of accepted zero results (+0 or -0), saturating.
- o_busy  output  1  high when the packer holds a half word or the FIFO is non-empty.

Behaviour:
- Reset values (cycle after rst high): o_valid=0, o_data=0, o_mask=0, o_last=0, o_zcnt=0, o_busy=0, o_ready=1. Packer is EMPTY, FIFO read/write pointers are 0. Reset mid-packet discards the half word and all FIFO contents.
- Handshakes:
  - Input accept = i_valid & o_ready.
  - Output pop = o_valid & i_ready.
  - o_ready = !fifo_full. It depends on registered state only; no combinational path from i_ready.
  - When the FIFO is full and a pop occurs, the same-cycle push is not allowed: o_ready is 0 that cycle.
- Packer FSM, two states:
  - EMPTY, accept, i_last=0: latch i_data into the low half, go to HALF, no FIFO write.
  - EMPTY, accept, i_last=1: write {32'h0, i_data}, mask 2'b01, last=1; stay EMPTY.
  - HALF, accept: write {i_data, low}, mask 2'b11, last=i_last; go to EMPTY.
  - No accept: hold state.
- Latency: an accept that completes a word makes o_valid high on the next cycle (FIFO registered, 1-cycle write-to-read). The FIFO head is presented directly on o_data, o_mask and o_last.
- The FIFO is a circular buffer of 2^DEPTH_LOG2 entries. Pointers are DEPTH_LOG2+1 bits; the extra MSB distinguishes full from empty. Pointers wrap naturally.
- Simultaneous push and pop when the FIFO is non-full and non-empty: occupancy is unchanged and both pointers advance.
- Zero counter:
  - Increments on accept when i_data[30:0]==0, so sign is ignored.
  - Saturates at 16'hFFFF.
  - i_zclr has priority over increment: in a clear cycle the counter becomes 0 and that cycle's zero is not counted.
  - rst clears it.
- o_busy = (state==HALF) | !fifo_empty, registered-state derived.
- No data modification: NaN, Inf and denormal patterns pass through bit-exact.

Test Plan:
- Reset then stream 0x3F800000, 0x40000000 (i_last on second), i_ready=1 → o_valid high one cycle after second accept; o_data=0x40000000_3F800000, o_mask=2'b11, o_last=1.
- Single element 0x00000000 with i_last, then i_zclr low → o_data=0x00000000_00000000, o_mask=2'b01, o_last=1; o_zcnt=1. Then 0x80000000 → o_zcnt=2.
- i_ready=0, stream 8 non-last elements with DEPTH_LOG2=2 → 4 words buffered, o_ready drops after 8th accept. Release i_ready → words drain in order with o_mask=2'b11, and o_ready returns the cycle after the first pop.
- Odd-length packet of 3 elements (A,B,C with i_last on C) → words {B,A}/mask 11/last 0, then {0,C}/mask 01/last 1.
- Assert rst while HALF with 2 words in FIFO → next cycle o_valid=0, o_busy=0, o_zcnt=0. A following 2-element packet is packed from EMPTY.
- Force o_zcnt to 16'hFFFE via zero stream, then 3 more zeros → holds 16'hFFFF. Then i_zclr together with a zero accept → o_zcnt=0.
